// File: rtl/ac_group_delay_line.sv
// ac_group_delay_line: multi-channel sampled-data group-delay element.
// Each channel owns a ring buffer; an accepted sample is written at that
// channel's write pointer while the sample written d entries earlier is
// read out, giving a delay of d samples of that same channel. One output
// register with a valid/ready handshake gives full throughput.
module ac_group_delay_line #(
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 32,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int DLY_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [DLY_W-1:0]  cfg_delay,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_data
);

    // The fill counter must be able to hold DEPTH itself, hence one extra bit.
    localparam int FILL_W = DLY_W + 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [CHANNELS][DEPTH];

    logic [DLY_W-1:0]  wptr_q [CHANNELS];
    logic [DLY_W-1:0]  wptr_d [CHANNELS];
    logic [FILL_W-1:0] fill_q [CHANNELS];
    logic [FILL_W-1:0] fill_d [CHANNELS];

    logic [DLY_W-1:0]  delay_q, delay_d;
    logic              outValid_q, outValid_d;
    logic [CH_W-1:0]   outCh_q, outCh_d;
    logic [DATA_W-1:0] outData_q, outData_d;

    logic              inReady;
    logic              accept;
    logic              chInRange;
    logic [DLY_W-1:0]  curWptr;
    logic [FILL_W-1:0] curFill;
    logic [DLY_W-1:0]  rdAddr;
    logic [DATA_W-1:0] rdData;

    // Handshake, history lookup and next-state for pointers, fills, delay and output register.
    always_comb begin
        inReady   = !cfg_we && (!outValid_q || out_ready);
        accept    = in_valid && inReady;
        chInRange = (int'(in_ch) < CHANNELS);

        curWptr = wptr_q[in_ch];
        curFill = fill_q[in_ch];
        rdAddr  = curWptr - delay_q;
        rdData  = mem_q[in_ch][rdAddr];

        wptr_d     = wptr_q;
        fill_d     = fill_q;
        delay_d    = delay_q;
        outValid_d = outValid_q;
        outCh_d    = outCh_q;
        outData_d  = outData_q;

        if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end

        if (cfg_we) begin
            delay_d = cfg_delay;
            for (int c = 0; c < CHANNELS; c++) begin
                fill_d[c] = '0;
            end
        end

        // Out-of-range channels are swallowed: accepted but leave no trace.
        if (accept && chInRange) begin
            outValid_d = 1'b1;
            outCh_d    = in_ch;
            if (delay_q == '0) begin
                outData_d = in_data;
            end else if (curFill < {1'b0, delay_q}) begin
                outData_d = '0;
            end else begin
                outData_d = rdData;
            end
            wptr_d[in_ch] = curWptr + 1'b1;
            if (curFill != FILL_MAX) begin
                fill_d[in_ch] = curFill + 1'b1;
            end
        end
    end

    // Control and output state, cleared asynchronously so a pending output vanishes on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wptr_q[c] <= '0;
                fill_q[c] <= '0;
            end
            delay_q    <= '0;
            outValid_q <= 1'b0;
            outCh_q    <= '0;
            outData_q  <= '0;
        end else begin
            wptr_q     <= wptr_d;
            fill_q     <= fill_d;
            delay_q    <= delay_d;
            outValid_q <= outValid_d;
            outCh_q    <= outCh_d;
            outData_q  <= outData_d;
        end
    end

    // Sample storage has no reset; stale contents are masked by the fill counters.
    always_ff @(posedge clk) begin
        if (accept && chInRange) begin
            mem_q[in_ch][curWptr] <= in_data;
        end
    end

    assign in_ready  = inReady;
    assign out_valid = outValid_q;
    assign out_ch    = outCh_q;
    assign out_data  = outData_q;

endmodule

// File: tb/tb_ac_group_delay_line.sv
// tb_ac_group_delay_line: scoreboard bench for ac_group_delay_line.
// Accepted samples are fed to a history-array model of the delay line and
// the expected outputs queued; an independent monitor pops and compares on
// every output handshake and also checks output hold and one-cycle latency.
module tb_ac_group_delay_line;

    localparam int DATA_W   = 16;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 32;
    localparam int CH_W     = 1;
    localparam int DLY_W    = 5;
    localparam int HIST_MAX = 4096;

    typedef struct {
        int          ch;
        logic [15:0] data;
        int          cyc;
    } expItem_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [DLY_W-1:0]  cfg_delay;
    logic              in_valid;
    logic              in_ready;
    logic [CH_W-1:0]   in_ch;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CH_W-1:0]   out_ch;
    logic [DATA_W-1:0] out_data;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    bit randReady = 1'b0;

    expItem_t    scoreQ[$];
    logic [15:0] histMem [CHANNELS][HIST_MAX];
    int          histCnt [CHANNELS];
    int          flushBase [CHANNELS];
    int          modelDelay;

    bit          holdPend;
    logic [CH_W-1:0]   heldCh;
    logic [DATA_W-1:0] heldData;
    int          firstSeen;

    ac_group_delay_line #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_delay(cfg_delay),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure accept-to-output latency.
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: every sample accepted into a channel is appended to its history;
    // the k-th sample since the last flush returns the (k-d)-th, or zero while k<d.
    always @(negedge clk) begin
        if (rst) begin
            scoreQ.delete();
            modelDelay = 0;
            for (int c = 0; c < CHANNELS; c++) begin
                histCnt[c]   = 0;
                flushBase[c] = 0;
            end
        end else begin
            if (cfg_we) begin
                modelDelay = int'(cfg_delay);
                for (int c = 0; c < CHANNELS; c++) flushBase[c] = histCnt[c];
            end
            if (in_valid && in_ready && int'(in_ch) < CHANNELS) begin
                int c;
                int n;
                logic [15:0] e;
                c = int'(in_ch);
                n = histCnt[c] - flushBase[c];
                if (modelDelay == 0) e = in_data;
                else if (n < modelDelay) e = 16'h0;
                else e = histMem[c][histCnt[c] - modelDelay];
                if (histCnt[c] < HIST_MAX) begin
                    histMem[c][histCnt[c]] = in_data;
                    histCnt[c]++;
                end
                scoreQ.push_back('{ch: c, data: e, cyc: cycle});
            end
        end
    end

    // Output monitor: compares each handshake against the scoreboard and checks hold/latency.
    always @(negedge clk) begin
        if (rst) begin
            holdPend = 1'b0;
        end else begin
            if (holdPend) begin
                checkOutput("holdValid", {31'b0, out_valid}, 32'd1);
                checkOutput("holdCh", {31'b0, out_ch}, {31'b0, heldCh});
                checkOutput("holdData", {16'b0, out_data}, {16'b0, heldData});
            end
            if (out_valid) begin
                if (!holdPend) firstSeen = cycle;
                if (out_ready) begin
                    holdPend = 1'b0;
                    if (scoreQ.size() == 0) begin
                        checkOutput("spuriousOutput", 32'd1, 32'd0);
                    end else begin
                        expItem_t it;
                        it = scoreQ.pop_front();
                        checkOutput("outCh", {31'b0, out_ch}, it.ch);
                        checkOutput("outData", {16'b0, out_data}, {16'b0, it.data});
                        checkOutput("latency", firstSeen, it.cyc + 1);
                    end
                end else begin
                    holdPend = 1'b1;
                    heldCh   = out_ch;
                    heldData = out_data;
                end
            end else begin
                holdPend = 1'b0;
            end
        end
    end

    // Present one sample and wait, bounded, until it is accepted.
    task automatic applyStimulus(input int ch, input logic [15:0] data, input bit mustAccept);
        bit done = 1'b0;
        int waitCnt = 0;
        in_valid = 1'b1;
        in_ch    = CH_W'(ch);
        in_data  = data;
        if (randReady) out_ready = ($urandom_range(0, 3) != 0);
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                if (mustAccept) checkOutput("inReadyStall", 32'd0, 32'd1);
                waitCnt++;
                if (waitCnt > 200) begin
                    checkOutput("acceptTimeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            if (!done && randReady) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
    endtask

    // Load a new delay; in_ready must be low in the cfg cycle.
    task automatic applyCfg(input int d);
        cfg_we    = 1'b1;
        cfg_delay = DLY_W'(d);
        @(negedge clk);
        checkOutput("cfgInReady", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // Let the scoreboard empty with out_ready high, bounded.
    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (scoreQ.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drainEmpty", scoreQ.size(), 32'd0);
    endtask

    task automatic checkResetState();
        checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
        checkOutput("rstOutCh", {31'b0, out_ch}, 32'd0);
        checkOutput("rstOutData", {16'b0, out_data}, 32'd0);
        checkOutput("rstInReady", {31'b0, in_ready}, 32'd1);
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        rst = 1'b1;
        cfg_we = 1'b0;
        cfg_delay = '0;
        in_valid = 1'b0;
        in_ch = '0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkResetState();

        // Ramp on one channel with delay 3, no stalls allowed.
        applyCfg(3);
        for (int k = 1; k <= 10; k++) applyStimulus(0, 16'(k), 1'b1);
        drain();

        // Bypass.
        applyCfg(0);
        applyStimulus(0, 16'h1234, 1'b1);
        drain();

        // Two interleaved channels with delay 2.
        applyCfg(2);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 16'(100 + k), 1'b1);
            applyStimulus(1, 16'(200 + k), 1'b1);
        end
        drain();

        // Backpressure: output held for four cycles, then same-cycle accept on release.
        applyStimulus(0, 16'd500, 1'b1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_ch = 1'b0;
        in_data = 16'd501;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("bpInReady", {31'b0, in_ready}, 32'd0);
            checkOutput("bpOutValid", {31'b0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bpRelease", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        applyStimulus(0, 16'd502, 1'b1);
        drain();

        // Wrap-around at the deepest delay, then reconfigure mid-stream.
        applyCfg(31);
        for (int k = 1; k <= 70; k++) applyStimulus(0, 16'(k), 1'b1);
        applyCfg(5);
        for (int k = 71; k <= 80; k++) applyStimulus(0, 16'(k), 1'b1);
        drain();

        // Randomized traffic with random backpressure and occasional reconfiguration.
        randReady = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) applyCfg(int'($urandom_range(0, DEPTH - 1)));
            applyStimulus(int'($urandom_range(0, CHANNELS - 1)), 16'($urandom), 1'b0);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        randReady = 1'b0;
        drain();

        // Asynchronous reset while an output is stalled.
        applyCfg(4);
        out_ready = 1'b0;
        applyStimulus(1, 16'hBEEF, 1'b1);
        @(posedge clk);
        #3;
        checkOutput("preRstOutValid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("asyncRstOutValid", {31'b0, out_valid}, 32'd0);
        checkOutput("asyncRstOutData", {16'b0, out_data}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checkResetState();
        applyStimulus(1, 16'h1234, 1'b1);
        applyStimulus(0, 16'h4321, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
